// File: rtl/pic_inta_isr_ctrl.sv
// INT/INTA sequencer for an 8259-style PIC in 8086 mode: raises INT, runs the
// two-pulse acknowledge, owns the in-service register and drives the vector byte.
module pic_inta_isr_ctrl #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               int_req,
    input  logic [ID_W-1:0]    int_id,
    input  logic               inta_n,
    input  logic               aeoi,
    input  logic               eoi_ns,
    input  logic               eoi_sp,
    input  logic [ID_W-1:0]    eoi_lvl,
    input  logic [4:0]         vec_base,
    output logic               int_out,
    output logic [NUM_IRQ-1:0] isr,
    output logic [NUM_IRQ-1:0] irr_clr,
    output logic [7:0]         vec_out,
    output logic               vec_oe
);

    typedef enum logic [2:0] {IDLE, PEND, ACK1, GAP, ACK2} state_t;

    localparam logic [ID_W-1:0] SPUR_ID = ID_W'(NUM_IRQ - 1);

    state_t            state, state_nxt;
    logic              inta_q;
    logic              fall, rise;
    logic [ID_W-1:0]   id_q;
    logic              spur_q;
    logic              ack_fall;
    logic [NUM_IRQ-1:0] eoi_clr, aeoi_clr, ack_set, isr_nxt;

    assign fall     = inta_q & ~inta_n;
    assign rise     = ~inta_q & inta_n;
    assign ack_fall = (state == PEND) && fall;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (int_req) state_nxt = PEND;
            PEND:    if (fall)    state_nxt = ACK1;
            ACK1:    if (rise)    state_nxt = GAP;
            GAP:     if (fall)    state_nxt = ACK2;
            ACK2:    if (rise)    state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    // EOI looks at the pre-update ISR; clears go in before the ACK1 set so set wins.
    always_comb begin
        eoi_clr = '0;
        if (eoi_sp)
            eoi_clr = NUM_IRQ'(1) << eoi_lvl;
        else if (eoi_ns)
            eoi_clr = isr & (~isr + NUM_IRQ'(1));
        aeoi_clr = '0;
        if ((state == ACK2) && rise && aeoi && !spur_q)
            aeoi_clr = NUM_IRQ'(1) << id_q;
        ack_set = '0;
        if (ack_fall && int_req)
            ack_set = NUM_IRQ'(1) << int_id;
        isr_nxt = (isr & ~(eoi_clr | aeoi_clr)) | ack_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            inta_q  <= 1'b1;
            isr     <= '0;
            irr_clr <= '0;
            id_q    <= '0;
            spur_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            inta_q  <= inta_n;
            isr     <= isr_nxt;
            irr_clr <= ack_set;
            if (ack_fall) begin
                id_q   <= int_req ? int_id : SPUR_ID;
                spur_q <= ~int_req;
            end
        end
    end

    assign int_out = (state == PEND);
    // Bus drive drops combinationally on the rising edge of the second pulse.
    assign vec_oe  = (state == ACK2) && !inta_n;
    assign vec_out = vec_oe ? {vec_base, id_q} : 8'h00;

endmodule

// File: tb/tb_pic_inta_isr_ctrl.sv
// Scoreboard bench: stimulus pushes expected irr_clr/vector events, a negedge
// monitor pops them whenever the DUT presents one; ISR tracked by a bit model.
module tb_pic_inta_isr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       int_req = 1'b0;
    logic [2:0] int_id = '0;
    logic       inta_n = 1'b1;
    logic       aeoi = 1'b0;
    logic       eoi_ns = 1'b0;
    logic       eoi_sp = 1'b0;
    logic [2:0] eoi_lvl = '0;
    logic [4:0] vec_base = '0;
    logic       int_out;
    logic [7:0] isr, irr_clr, vec_out;
    logic       vec_oe;

    int checks = 0;
    int passed = 0;
    logic [7:0] mdl_isr = '0;
    logic [7:0] exp_vec_q[$];
    logic [7:0] exp_irr_q[$];
    logic       vec_oe_prev = 1'b0;

    pic_inta_isr_ctrl dut (
        .clk(clk), .rst_n(rst_n), .int_req(int_req), .int_id(int_id), .inta_n(inta_n),
        .aeoi(aeoi), .eoi_ns(eoi_ns), .eoi_sp(eoi_sp), .eoi_lvl(eoi_lvl), .vec_base(vec_base),
        .int_out(int_out), .isr(isr), .irr_clr(irr_clr), .vec_out(vec_out), .vec_oe(vec_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference EOI: specific beats non-specific; x & (x-1) drops the lowest set bit.
    function automatic logic [7:0] apply_eoi(input logic [7:0] cur, input logic ns,
                                             input logic sp, input logic [2:0] lvl);
        logic [7:0] r;
        r = cur;
        if (sp) r[lvl] = 1'b0;
        else if (ns) r = cur & (cur - 8'd1);
        return r;
    endfunction

    // Monitor: every irr_clr pulse and every vector drive must match a queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (irr_clr != 8'h00) begin
                if (exp_irr_q.size() == 0) chk("irr_clr_unexpected", irr_clr, 8'h00);
                else chk("irr_clr", irr_clr, exp_irr_q.pop_front());
            end
            if (vec_oe && !vec_oe_prev) begin
                if (exp_vec_q.size() == 0) chk("vec_oe_unexpected", {7'd0, vec_oe}, 8'h00);
                else chk("vec_out", vec_out, exp_vec_q.pop_front());
            end
        end
        vec_oe_prev = vec_oe & rst_n;
    end

    task automatic do_eoi(input logic ns, input logic sp, input logic [2:0] lvl);
        eoi_ns = ns; eoi_sp = sp; eoi_lvl = lvl;
        step();
        eoi_ns = 0; eoi_sp = 0;
        mdl_isr = apply_eoi(mdl_isr, ns, sp, lvl);
        chk("isr_after_eoi", isr, mdl_isr);
    endtask

    // One full INT/INTA transaction; optional EOI on the first fall, optional reset in GAP.
    task automatic do_int(input logic [2:0] id, input logic spur, input logic ae,
                          input logic ens, input logic esp, input logic [2:0] elvl,
                          input logic abort);
        logic [2:0] vid;
        aeoi = ae;
        chk("int_out_idle", {7'd0, int_out}, 8'h00);
        int_req = 1; int_id = id;
        step();
        chk("int_out_latency", {7'd0, int_out}, 8'h01);
        if (spur) begin
            int_req = 0;
            step();
            chk("int_out_held", {7'd0, int_out}, 8'h01);
        end
        vid = spur ? 3'd7 : id;
        if (!spur) exp_irr_q.push_back(8'h01 << id);
        if (!abort) exp_vec_q.push_back({vec_base, vid});
        inta_n = 0; eoi_ns = ens; eoi_sp = esp; eoi_lvl = elvl;
        step();
        eoi_ns = 0; eoi_sp = 0; int_req = 0;
        mdl_isr = apply_eoi(mdl_isr, ens, esp, elvl);
        if (!spur) mdl_isr[id] = 1'b1;
        chk("int_out_ack1", {7'd0, int_out}, 8'h00);
        chk("isr_ack1", isr, mdl_isr);
        chk("vec_oe_ack1", {7'd0, vec_oe}, 8'h00);
        step();
        inta_n = 1;
        step();
        chk("vec_oe_gap", {7'd0, vec_oe}, 8'h00);
        if (abort) begin
            rst_n = 0;
            #1;
            mdl_isr = '0;
            chk("isr_rst", isr, 8'h00);
            chk("int_out_rst", {7'd0, int_out}, 8'h00);
            chk("vec_oe_rst", {7'd0, vec_oe}, 8'h00);
            step();
            rst_n = 1;
            step();
        end
        step();
        inta_n = 0;
        step();
        if (!abort) chk("vec_oe_ack2", {7'd0, vec_oe}, 8'h01);
        else chk("vec_oe_after_rst", {7'd0, vec_oe}, 8'h00);
        step();
        inta_n = 1;
        #1;
        chk("vec_oe_rise", {7'd0, vec_oe}, 8'h00);
        step();
        if (!abort && ae && !spur) mdl_isr[id] = 1'b0;
        chk("isr_end", isr, mdl_isr);
        step();
    endtask

    initial begin
        vec_base = 5'h01;
        #1;
        chk("rst_int_out", {7'd0, int_out}, 8'h00);
        chk("rst_isr", isr, 8'h00);
        chk("rst_irr_clr", irr_clr, 8'h00);
        chk("rst_vec", vec_out, 8'h00);
        chk("rst_vec_oe", {7'd0, vec_oe}, 8'h00);
        step();
        rst_n = 1;
        step();

        do_int(3'd3, 0, 0, 0, 0, 3'd0, 0);           // normal EOI: isr=08, vec 0B
        do_eoi(0, 1, 3'd3);
        do_int(3'd3, 0, 1, 0, 0, 3'd0, 0);           // AEOI clears on pulse-2 rise
        do_int(3'd5, 1, 0, 0, 0, 3'd0, 0);           // spurious -> vec 0F
        do_int(3'd1, 0, 0, 0, 0, 3'd0, 0);
        do_int(3'd3, 0, 0, 0, 0, 3'd0, 0);           // isr = 0A
        do_eoi(1, 0, 3'd0);                          // -> 08
        do_eoi(0, 1, 3'd3);                          // -> 00
        do_eoi(1, 0, 3'd0);                          // empty isr: no-op
        do_int(3'd0, 0, 0, 0, 0, 3'd0, 0);           // isr = 01
        do_int(3'd0, 0, 0, 1, 0, 3'd0, 0);           // eoi_ns on fall: set wins
        do_eoi(1, 1, 3'd4);                          // both: specific only
        do_eoi(0, 1, 3'd0);
        do_int(3'd4, 0, 0, 0, 0, 3'd0, 0);           // isr = 10, reset in GAP
        do_int(3'd2, 0, 0, 0, 0, 3'd0, 1);

        for (int i = 0; i < 40; i++) begin
            vec_base = 5'($urandom);
            if ($urandom_range(0, 2) == 0)
                do_eoi(1'($urandom), 1'($urandom), 3'($urandom));
            do_int(3'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), 3'($urandom),
                   ($urandom_range(0, 12) == 0));
        end

        step();
        chk("vec_q_drained", 8'(exp_vec_q.size()), 8'h00);
        chk("irr_q_drained", 8'(exp_irr_q.size()), 8'h00);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
